// File: rtl/i2f_pkg.sv
// Shared definitions for the int32 -> fp32 sequential converter.
// Holds the FSM state type, the IEEE-754 single-precision field widths and
// the normalisation shift table used by the binary-search left shift.
package i2f_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_OUT
  } state_e;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int EXP_BIAS = 127;
  // Exponent of a magnitude whose leading one already sits in bit 31.
  localparam int EXP_TOP  = EXP_BIAS + 31;

  localparam int NORM_STEPS = 5;
  // Shift amount tried at each NORM step, largest first.
  localparam logic [4:0] NORM_SHIFT [NORM_STEPS] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

endpackage

// File: rtl/i2f_round_rne.sv
// Round-to-nearest-even packer for the int32 -> fp32 converter.
// Takes a magnitude already normalised so its leading one is in bit 31,
// the left-shift count that got it there and the sign, and produces the
// packed single-precision word plus the inexact flag.
module i2f_round_rne
  import i2f_pkg::*;
(
  input  logic [31:0] mag_i,
  input  logic [4:0]  lz_i,
  input  logic        sign_i,
  output logic [31:0] data_o,
  output logic        inexact_o
);

  logic [FP_MAN_W-1:0] manTrunc;
  logic [FP_MAN_W:0]   manSum;
  logic [FP_EXP_W-1:0] expVal;
  logic                guardBit;
  logic                stickyBit;
  logic                lsbBit;
  logic                roundUp;

  // Split off guard/sticky, round ties to even, fold mantissa carry into the exponent.
  always_comb begin
    manTrunc  = mag_i[30:8];
    guardBit  = mag_i[7];
    stickyBit = |mag_i[6:0];
    lsbBit    = mag_i[8];
    roundUp   = guardBit & (stickyBit | lsbBit);
    manSum    = {1'b0, manTrunc} + {{FP_MAN_W{1'b0}}, roundUp};
    expVal    = FP_EXP_W'(EXP_TOP) - {3'b000, lz_i}
              + {{(FP_EXP_W-1){1'b0}}, manSum[FP_MAN_W]};
    data_o    = {sign_i, expVal, manSum[FP_MAN_W-1:0]};
    inexact_o = guardBit | stickyBit;
    // After normalisation a clear top bit can only mean the input was zero.
    if (!mag_i[31]) begin
      data_o    = '0;
      inexact_o = 1'b0;
    end
  end

endmodule

// File: rtl/int32_to_fp32_seq.sv
// Sequential 32-bit integer to IEEE-754 single converter.
// Accepts one integer in IDLE, normalises it with a five-step binary-search
// left shift (16/8/4/2/1, one step per cycle), rounds to nearest-even and
// holds the result until downstream accepts it.
// Optional build macro: I2F_UNSIGNED_EN adds the in_is_unsigned input.
module int32_to_fp32_seq
  import i2f_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
`ifdef I2F_UNSIGNED_EN
  input  logic        in_is_unsigned,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  lz_q, lz_d;
  logic        sign_q, sign_d;
  logic [31:0] outData_q, outData_d;
  logic        outInexact_q, outInexact_d;

  logic        isUnsigned;
  logic        negIn;
  logic [4:0]  shiftAmt;
  logic [31:0] topMask;
  logic [31:0] roundData;
  logic        roundInexact;

  i2f_round_rne u_round (
    .mag_i     (mag_q),
    .lz_i      (lz_q),
    .sign_i    (sign_q),
    .data_o    (roundData),
    .inexact_o (roundInexact)
  );

  // State and datapath registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      mag_q        <= '0;
      lz_q         <= '0;
      sign_q       <= 1'b0;
      outData_q    <= '0;
      outInexact_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      mag_q        <= mag_d;
      lz_q         <= lz_d;
      sign_q       <= sign_d;
      outData_q    <= outData_d;
      outInexact_q <= outInexact_d;
    end
  end

  // Next-state logic: capture, normalise step by step, round, then hold for handshake.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    mag_d        = mag_q;
    lz_d         = lz_q;
    sign_d       = sign_q;
    outData_d    = outData_q;
    outInexact_d = outInexact_q;

`ifdef I2F_UNSIGNED_EN
    isUnsigned = in_is_unsigned;
`else
    isUnsigned = 1'b0;
`endif
    negIn    = in_data[31] & ~isUnsigned;
    shiftAmt = (step_q < 3'(NORM_STEPS)) ? NORM_SHIFT[step_q] : 5'd0;
    topMask  = ~(32'hFFFF_FFFF >> shiftAmt);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = negIn;
          mag_d   = negIn ? (~in_data + 32'd1) : in_data;
          lz_d    = '0;
          step_d  = '0;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if ((mag_q & topMask) == 32'd0) begin
          mag_d = mag_q << shiftAmt;
          lz_d  = lz_q + shiftAmt;
        end
        if (step_q == 3'(NORM_STEPS - 1)) begin
          state_d = ST_ROUND;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ST_ROUND: begin
        outData_d    = roundData;
        outInexact_d = roundInexact;
        state_d      = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_OUT);
  assign out_data    = outData_q;
  assign out_inexact = outInexact_q;

endmodule
